// File: rtl/sync_debouncer_pkg.sv
// rtl/sync_debouncer_pkg.sv - common constants for the input conditioner
package sync_debouncer_pkg;

    // Shallowest synchronizer chain considered safe against metastability.
    localparam int SYNC_MIN_STAGES = 2;

endpackage

// File: rtl/sync_debouncer_debounce_channel.sv
// rtl/sync_debouncer_debounce_channel.sv - one debounced channel with edge pulses
//
// Ports:
//   clk      rising-edge clock
//   resetN   asynchronous active-low reset
//   syncIn   already-synchronized input level
//   dataOut  debounced level, RESET_VALUE after reset
//   rise     one-cycle pulse when dataOut goes 0->1
//   fall     one-cycle pulse when dataOut goes 1->0
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic resetN,
    input  logic syncIn,
    output logic dataOut,
    output logic rise,
    output logic fall
);

    if (DEBOUNCE_CYCLES == 0) begin : gBypass
        // Registered pass-through; edges can occur on consecutive cycles.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                dataOut <= RESET_VALUE;
                rise    <= 1'b0;
                fall    <= 1'b0;
            end else begin
                dataOut <= syncIn;
                rise    <= syncIn & ~dataOut;
                fall    <= ~syncIn & dataOut;
            end
        end
    end else begin : gDebounce
        localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt;

        // cnt counts consecutive edges of disagreement; any agreement restarts it,
        // so the level flips only after DEBOUNCE_CYCLES disagreeing edges in a row.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                cnt     <= '0;
                dataOut <= RESET_VALUE;
                rise    <= 1'b0;
                fall    <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (syncIn == dataOut) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    dataOut <= syncIn;
                    rise    <= syncIn;
                    fall    <= ~syncIn;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_debouncer.sv
// rtl/sync_debouncer.sv - multi-channel synchronizer, debouncer and edge detector
//
// Ports:
//   clk      rising-edge clock
//   resetN   asynchronous active-low reset
//   dataIn   [LEN] raw asynchronous inputs, read only by the sync chain
//   dataOut  [LEN] synchronized, debounced levels
//   rise     [LEN] one-cycle pulses on dataOut 0->1
//   fall     [LEN] one-cycle pulses on dataOut 1->0
module sync_debouncer #(
    parameter int             LEN             = 1,
    parameter int             STAGES          = 2,
    parameter int             DEBOUNCE_CYCLES = 4,
    parameter logic [LEN-1:0] RESET_VALUE     = '0
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic [LEN-1:0] dataIn,
    output logic [LEN-1:0] dataOut,
    output logic [LEN-1:0] rise,
    output logic [LEN-1:0] fall
);

    import sync_debouncer_pkg::*;

    if (STAGES < SYNC_MIN_STAGES) begin : gStagesCheck
        $error("sync_debouncer: STAGES must be >= SYNC_MIN_STAGES");
    end

    // Index 0 samples dataIn; index STAGES-1 is the synchronized level.
    logic [STAGES-1:0][LEN-1:0] syncReg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            syncReg <= {STAGES{RESET_VALUE}};
        end else begin
            syncReg <= {syncReg[STAGES-2:0], dataIn};
        end
    end

    for (genvar i = 0; i < LEN; i++) begin : gChan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) uChan (
            .clk     (clk),
            .resetN  (resetN),
            .syncIn  (syncReg[STAGES-1][i]),
            .dataOut (dataOut[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_debouncer.sv
// tb/tb_sync_debouncer.sv - scoreboard bench for sync_debouncer
module tb_sync_debouncer;

    logic       clk = 1'b0;
    logic       clkEn = 1'b1;
    logic       resetN;
    logic [1:0] dataIn;
    logic [1:0] dataOut, rise, fall;
    logic [1:0] bpIn;
    logic [1:0] bpOut, bpRise, bpFall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] d, r, f, bd, br, bf;
    } exp_t;

    exp_t expQ[$];

    always #1 clk = clkEn ? ~clk : clk;

    sync_debouncer #(
        .LEN(2), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(2'b00)
    ) dut (
        .clk(clk), .resetN(resetN), .dataIn(dataIn),
        .dataOut(dataOut), .rise(rise), .fall(fall)
    );

    sync_debouncer #(
        .LEN(2), .STAGES(3), .DEBOUNCE_CYCLES(0), .RESET_VALUE(2'b00)
    ) dutBp (
        .clk(clk), .resetN(resetN), .dataIn(bpIn),
        .dataOut(bpOut), .rise(bpRise), .fall(bpFall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, expv, $time);
        end
    endtask

    task automatic pushExp(input string tag, input logic [1:0] d, r, f, bd, br, bf, input int n);
        exp_t e;
        e.tag = tag; e.d = d; e.r = r; e.f = f; e.bd = bd; e.br = br; e.bf = bf;
        repeat (n) expQ.push_back(e);
    endtask

    // Advance n clock edges, sampling on each following falling edge.
    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (expQ.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                chk({e.tag, ".dataOut"}, dataOut, e.d);
                chk({e.tag, ".rise"},    rise,    e.r);
                chk({e.tag, ".fall"},    fall,    e.f);
                chk({e.tag, ".bpOut"},   bpOut,   e.bd);
                chk({e.tag, ".bpRise"},  bpRise,  e.br);
                chk({e.tag, ".bpFall"},  bpFall,  e.bf);
            end
        end
    endtask

    initial begin
        resetN = 1'b0;
        dataIn = 2'b11;
        bpIn   = 2'b00;

        // Reset held with inputs high: everything stays at reset value.
        pushExp("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        step(3);

        resetN = 1'b1;
        dataIn = 2'b00;
        pushExp("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        step(3);

        // Step 0->3: five edges unchanged, sixth edge flips with a rise pulse.
        dataIn = 2'b11;
        pushExp("step_wait", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        pushExp("step_rise", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        pushExp("step_hold", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        step(9);

        // Three-cycle low glitch on bit 0 is filtered.
        dataIn = 2'b10;
        pushExp("glitch", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        step(3);
        dataIn = 2'b11;
        pushExp("glitch_after", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8);
        step(8);

        // Sustained low on bit 0: fall after six edges.
        dataIn = 2'b10;
        pushExp("low_wait", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        pushExp("low_fall", 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        pushExp("low_hold", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        step(8);

        // Toggle bit 1 every cycle: never passes the debouncer.
        for (int k = 0; k < 20; k++) begin
            dataIn[1] = ~dataIn[1];
            pushExp("toggle", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
            step(1);
        end
        pushExp("toggle_settle", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6);
        step(6);

        // Bring dataOut to 3 again, then assert reset with the clock stopped.
        dataIn = 2'b11;
        pushExp("rise0_wait", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        pushExp("rise0", 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        pushExp("rise0_hold", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        step(7);
        clkEn  = 1'b0;
        resetN = 1'b0;
        #3;
        chk("async_rst.clk_stopped", clk, 1'b0);
        chk("async_rst.dataOut", dataOut, 2'b00);
        chk("async_rst.rise", rise, 2'b00);
        chk("async_rst.fall", fall, 2'b00);
        clkEn = 1'b1;
        pushExp("async_rst_hold", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        step(2);

        // Reset in the middle of a debounce count.
        dataIn = 2'b00;
        resetN = 1'b1;
        pushExp("mid_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        step(3);
        dataIn = 2'b11;
        pushExp("mid_count", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        step(4);
        resetN = 1'b0;
        pushExp("mid_rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        step(2);
        resetN = 1'b1;
        pushExp("post_rst_wait", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        pushExp("post_rst_rise", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        pushExp("post_rst_hold", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        step(8);

        // Bypass instance: latency STAGES+1 = 4 edges.
        bpIn = 2'b11;
        pushExp("bp_wait", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        pushExp("bp_rise", 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1);
        pushExp("bp_hold", 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2);
        step(6);
        bpIn = 2'b00;
        pushExp("bp_wait0", 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 3);
        pushExp("bp_fall", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1);
        pushExp("bp_hold0", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        step(6);

        // One-cycle input pulse passes through bypass as back-to-back rise/fall.
        bpIn = 2'b01;
        pushExp("bp_pw", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        pushExp("bp_prise", 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1);
        pushExp("bp_pfall", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        pushExp("bp_pidle", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        step(1);
        bpIn = 2'b00;
        step(6);

        chk("scoreboard_drained", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_debouncer.md
Name: sync_debouncer

Overview:
Multi-channel input conditioner for asynchronous external signals such as buttons, switches and GPIO inputs. Each channel runs through a parametrised flip-flop synchronizer chain, then a per-channel debounce counter. Each channel produces a stable level output plus single-cycle rising- and falling-edge pulses. It sits between the top-level pins and the MMIO/GPIO peripheral logic, and generalises the existing plain synchronizer with debouncing, edge detection and a defined reset value.

Parameters:
LEN, 1, number of independent channels.
STAGES, 2, synchronizer flip-flop stages per channel; legal range >= 2.
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the output changes; 0 = debounce bypass.
RESET_VALUE, '0, LEN-bit value loaded into every sync stage and into dataOut on reset.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
resetN  input  1  asynchronous, active-low reset.
dataIn  input  LEN  asynchronous raw inputs.
dataOut  output  LEN  synchronized, debounced level.
rise  output  LEN  one-cycle pulse when dataOut[i] goes 0->1.
fall  output  LEN  one-cycle pulse when dataOut[i] goes 1->0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - resetN low immediately forces all sync stages = RESET_VALUE, dataOut = RESET_VALUE, all counters = 0, rise = fall = 0.
  - Deassertion is sampled at the first following clk edge.
- Synchronizer: a STAGES-deep shift register per channel.
  - Its last stage is s[i].
  - A dataIn change that meets setup before edge k is visible on s at edge k+STAGES-1.
  - No other logic reads dataIn directly.
- Debounce, per channel (DEBOUNCE_CYCLES >= 1):
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - At each edge where s[i] == dataOut[i]: cnt <= 0.
  - At each edge where s[i] != dataOut[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - At each edge where s[i] != dataOut[i] and cnt == DEBOUNCE_CYCLES-1: dataOut[i] <= s[i], cnt <= 0.
  - The output therefore changes only after DEBOUNCE_CYCLES consecutive edges of disagreement.
  - Any single-edge return to agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES are filtered completely.
- Total latency from an input change to the dataOut change is STAGES + DEBOUNCE_CYCLES edges. With defaults that is 6 edges.
- DEBOUNCE_CYCLES == 0: no counters are instantiated; dataOut[i] <= s[i] every edge, giving a registered bypass with latency STAGES+1.
- Edge pulses:
  - rise[i] and fall[i] are registered and asserted in the same cycle dataOut[i] takes its new value.
  - They are high for exactly one cycle and never both high on one channel.
  - Back-to-back edges are separated by at least DEBOUNCE_CYCLES cycles, or 1 cycle in bypass.
- Channels are fully independent; simultaneous changes on several channels give simultaneous pulses.
- Reset mid-count: the counter is cleared and no pulse is issued. After reset no pulse is generated unless s later differs from RESET_VALUE for the full debounce window.
- No combinational path exists from dataIn to any output.

Decomposition:
- No shared-package typedefs are needed.
- Add a constant SYNC_MIN_STAGES = 2 to the common constants package; an elaboration-time check asserts STAGES >= SYNC_MIN_STAGES.
- Sub-module debounce_channel (one channel: counter, level register, rise/fall registers; parameter DEBOUNCE_CYCLES, RESET_VALUE bit) is instantiated LEN times by a generate loop.
- The sync chain stays in the top module as a 2-D register array.

Test Plan:
Defaults LEN=2, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0, clk period 2.
1. Hold resetN low, drive dataIn=3 -> dataOut=0, rise=fall=0 while reset is low; asynchronous assertion clears a previously set dataOut=3 without waiting for a clock edge.
2. Release reset, step dataIn 0->3 and hold -> dataOut stays 0 for 5 edges, becomes 3 on the 6th edge; rise=3 for exactly that one cycle; fall=0 throughout.
3. From dataOut=3, pulse dataIn[0] low for 3 cycles -> dataOut stays 3, no fall pulse; then hold it low for 4+ cycles -> dataOut=2 after 6 edges, fall=1 for one cycle.
4. Toggle dataIn[1] every cycle for 20 cycles -> dataOut[1] and rise[1]/fall[1] never change.
5. Assert resetN mid-count (dataIn 0->3, reset after 4 edges) -> counters cleared, no pulse; after release with dataIn=3 held, dataOut=3 appears 6 edges after the first sampled edge.
6. Instance with DEBOUNCE_CYCLES=0, STAGES=3 -> a dataIn step reaches dataOut after 4 edges, with a one-cycle rise/fall pulse on each change.
